// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush controller for a five-stage in-order pipeline. It
// decides each cycle whether the front end holds, whether a taken branch
// squashes the wrong-path fetch, and whether a load-use hazard inserts a
// bubble. It also sequences the single outstanding external memory access
// issued from the MEM stage and enters a sticky error state when that access
// is not completed within MEM_TIMEOUT wait cycles.
//
// Control outputs are combinational from the state register and the current
// inputs, so the pipeline registers see them in the same cycle as the
// condition that caused them.
//
// Parameters
//   MEM_TIMEOUT : MEM_WAIT cycles allowed for one access before ERROR (>= 1)
//   CNT_W       : width of the performance counters
//
// Optional feature
//   STALL_COUNTER_EN : when defined, the three performance counters are
//                      implemented (saturating). When undefined the counter
//                      ports remain but are tied to zero and no counter
//                      flops exist.
//
// Ports
//   clk             in   single clock, rising edge
//   rst             in   synchronous active-high reset
//   hazard_detected in   data hazard from the ID-stage hazard unit
//   branch_taken    in   taken branch/jump resolved in EXE
//   mem_r_en        in   MEM-stage load
//   mem_w_en        in   MEM-stage store
//   sram_ready      in   external memory completes the access this cycle
//   sram_req        out  memory access request
//   freeze_pc       out  hold PC
//   freeze_if_id    out  hold IF/ID register
//   flush_if_id     out  clear IF/ID register to NOP
//   bubble_id_exe   out  load NOP into ID/EXE register
//   freeze_back     out  hold ID/EXE, EXE/MEM and MEM/WB registers
//   mem_error       out  high exactly while in ERROR (sticky until rst)
//   stall_cnt       out  hazard-bubble cycles
//   mem_wait_cnt    out  memory stall cycles
//   flush_cnt       out  branch flushes
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             sram_ready,
    output logic             sram_req,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             freeze_back,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter only needs to reach MEM_TIMEOUT; one spare bit for the
    // incremented value used in the timeout compare.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W:0] TIMEOUT_V = MEM_TIMEOUT[WAIT_W:0];
    localparam logic [WAIT_W:0] WAIT_ONE  = {{WAIT_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t              state_r;
    logic [WAIT_W-1:0]   wait_cnt_r;

    logic                mem_access_s;
    logic                sram_req_s;
    logic                mem_stall_s;
    logic                in_error_s;
    logic [WAIT_W:0]     wait_cnt_inc_s;
    logic                wait_done_s;

    // Memory request and stall qualification from state and MEM-stage enables.
    always_comb begin
        mem_access_s = mem_r_en | mem_w_en;
        sram_req_s   = 1'b0;
        case (state_r)
            ST_RUN:      sram_req_s = mem_access_s;
            ST_MEM_WAIT: sram_req_s = 1'b1;
            ST_ERROR:    sram_req_s = 1'b0;
            default:     sram_req_s = 1'b0;
        endcase
        mem_stall_s = sram_req_s & ~sram_ready;
        in_error_s  = (state_r == ST_ERROR);
    end

    // The registered wait count holds completed MEM_WAIT cycles, so the
    // incremented value is the wait count including the current cycle: the
    // access times out at the end of the MEM_TIMEOUT-th MEM_WAIT cycle.
    always_comb begin
        wait_cnt_inc_s = {1'b0, wait_cnt_r} + WAIT_ONE;
        wait_done_s    = (wait_cnt_inc_s == TIMEOUT_V);
    end

    // Pipeline control with priority ERROR > memory stall > branch > hazard.
    always_comb begin
        sram_req      = sram_req_s;
        mem_error     = in_error_s;
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        freeze_back   = 1'b0;
        if (in_error_s || mem_stall_s) begin
            // Whole pipeline holds; branch/hazard are re-evaluated once it moves.
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            freeze_back  = 1'b1;
        end else if (branch_taken) begin
            // PC keeps running so the branch target is fetched next.
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
        end else if (hazard_detected) begin
            freeze_pc     = 1'b1;
            freeze_if_id  = 1'b1;
            bubble_id_exe = 1'b1;
        end else begin
            freeze_pc     = 1'b0;
            freeze_if_id  = 1'b0;
            flush_if_id   = 1'b0;
            bubble_id_exe = 1'b0;
            freeze_back   = 1'b0;
        end
    end

    // Memory-access state machine and its wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Abandons any in-flight access.
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    wait_cnt_r <= {WAIT_W{1'b0}};
                    if (mem_stall_s) begin
                        state_r <= ST_MEM_WAIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (sram_ready) begin
                        // Completion wins over a coincident timeout.
                        state_r    <= ST_RUN;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else if (wait_done_s) begin
                        state_r    <= ST_ERROR;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= wait_cnt_inc_s[WAIT_W-1:0];
                    end
                end
                ST_ERROR: begin
                    // Absorbing until reset.
                    state_r    <= ST_ERROR;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
                default: begin
                    state_r    <= ST_RUN;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef STALL_COUNTER_EN

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] mem_wait_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             stall_evt_s;
    logic             flush_evt_s;

    // Events that count: a hazard bubble only when nothing of higher priority
    // claimed the cycle, a flush only when the branch actually took effect.
    always_comb begin
        stall_evt_s = hazard_detected & ~branch_taken & ~mem_stall_s & ~in_error_s;
        flush_evt_s = branch_taken & ~mem_stall_s & ~in_error_s;
    end

    // Performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r    <= {CNT_W{1'b0}};
            mem_wait_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (mem_stall_s) begin
                mem_wait_cnt_r <= sat_inc(mem_wait_cnt_r);
            end else begin
                mem_wait_cnt_r <= mem_wait_cnt_r;
            end
            if (flush_evt_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt    = stall_cnt_r;
    assign mem_wait_cnt = mem_wait_cnt_r;
    assign flush_cnt    = flush_cnt_r;

`else

    assign stall_cnt    = {CNT_W{1'b0}};
    assign mem_wait_cnt = {CNT_W{1'b0}};
    assign flush_cnt    = {CNT_W{1'b0}};

`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// Testbench for pipeline_stall_controller. Directed scenarios, one task each.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge. Counter expectations depend on
// whether STALL_COUNTER_EN is defined for the build.
// Control vector order: {sram_req, freeze_pc, freeze_if_id, flush_if_id,
//                        bubble_id_exe, freeze_back}
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
`ifdef STALL_COUNTER_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_HAZARD = 6'b011010;
    localparam logic [5:0] C_BRANCH = 6'b000110;
    localparam logic [5:0] C_STALL  = 6'b111001;
    localparam logic [5:0] C_ERROR  = 6'b011001;
    localparam logic [5:0] C_ACCESS = 6'b100000;
    localparam logic [5:0] C_ACC_BR = 6'b100110;
    localparam logic [5:0] C_ACC_HZ = 6'b111010;

    logic             clk = 1'b0;
    logic             rst;
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             sram_ready;
    logic             sram_req;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             flush_if_id;
    logic             bubble_id_exe;
    logic             freeze_back;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [5:0]       ctl;

    int checks = 0;
    int errors = 0;

    pipeline_stall_controller #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_detected(hazard_detected),
        .branch_taken   (branch_taken),
        .mem_r_en       (mem_r_en),
        .mem_w_en       (mem_w_en),
        .sram_ready     (sram_ready),
        .sram_req       (sram_req),
        .freeze_pc      (freeze_pc),
        .freeze_if_id   (freeze_if_id),
        .flush_if_id    (flush_if_id),
        .bubble_id_exe  (bubble_id_exe),
        .freeze_back    (freeze_back),
        .mem_error      (mem_error),
        .stall_cnt      (stall_cnt),
        .mem_wait_cnt   (mem_wait_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign ctl = {sram_req, freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back};

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] cexp(input int n);
        return CNT_ON ? CNT_W'(n) : {CNT_W{1'b0}};
    endfunction

    // Drive all functional inputs; called right after a falling edge.
    task automatic set_in(input logic hz, input logic br, input logic rd,
                          input logic wr, input logic rdy);
        hazard_detected = hz;
        branch_taken    = br;
        mem_r_en        = rd;
        mem_w_en        = wr;
        sram_ready      = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (ctl !== C_IDLE || mem_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b err=%b expected ctl=%b err=0", ctl, mem_error, C_IDLE);
        end
        checks++;
        if (stall_cnt !== 16'd0 || mem_wait_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", stall_cnt, mem_wait_cnt, flush_cnt);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (ctl !== C_HAZARD) begin
                errors++;
                $display("FAIL hazard_cycle%0d: ctl=%b expected %b", i, ctl, C_HAZARD);
            end
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL hazard_release: ctl=%b expected %b", ctl, C_IDLE);
        end
        checks++;
        if (stall_cnt !== cexp(2)) begin
            errors++;
            $display("FAIL hazard_stall_cnt: got %0d expected %0d", stall_cnt, cexp(2));
        end
    endtask

    task automatic test_branch_hazard();
        do_reset();
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++;
            $display("FAIL branch_over_hazard: ctl=%b expected %b", ctl, C_BRANCH);
        end
        // Access completing immediately does not stall, so the branch still acts.
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (ctl !== C_ACC_BR) begin
            errors++;
            $display("FAIL branch_with_ready_access: ctl=%b expected %b", ctl, C_ACC_BR);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (flush_cnt !== cexp(2) || stall_cnt !== cexp(0) || mem_wait_cnt !== cexp(0)) begin
            errors++;
            $display("FAIL branch_counters: got flush=%0d stall=%0d wait=%0d expected %0d/%0d/%0d",
                     flush_cnt, stall_cnt, mem_wait_cnt, cexp(2), cexp(0), cexp(0));
        end
    endtask

    task automatic test_mem_read();
        do_reset();
        // Cycle 0 in RUN, cycles 1-2 in MEM_WAIT; hazard/branch must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(i == 1, i == 2, 1'b1, 1'b0, 1'b0);
            #1;
            checks++;
            if (ctl !== C_STALL) begin
                errors++;
                $display("FAIL mem_read_wait%0d: ctl=%b expected %b", i, ctl, C_STALL);
            end
        end
        // Completion cycle: request still up, no freeze, branch now acts.
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (ctl !== C_ACC_BR) begin
            errors++;
            $display("FAIL mem_read_done: ctl=%b expected %b", ctl, C_ACC_BR);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL mem_read_back_in_run: ctl=%b expected %b", ctl, C_IDLE);
        end
        checks++;
        if (mem_wait_cnt !== cexp(3) || flush_cnt !== cexp(1) || stall_cnt !== cexp(0)) begin
            errors++;
            $display("FAIL mem_read_counters: got wait=%0d flush=%0d stall=%0d expected %0d/%0d/%0d",
                     mem_wait_cnt, flush_cnt, stall_cnt, cexp(3), cexp(1), cexp(0));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL timeout_issue: ctl=%b expected %b", ctl, C_STALL);
        end
        for (int i = 1; i <= MEM_TIMEOUT; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (ctl !== C_STALL || mem_error !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: ctl=%b err=%b expected ctl=%b err=0", i, ctl, mem_error, C_STALL);
            end
        end
        // ERROR holds whatever the inputs do.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(i[0], 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (ctl !== C_ERROR || mem_error !== 1'b1) begin
                errors++;
                $display("FAIL timeout_error%0d: ctl=%b err=%b expected ctl=%b err=1", i, ctl, mem_error, C_ERROR);
            end
        end
        checks++;
        if (mem_wait_cnt !== cexp(16)) begin
            errors++;
            $display("FAIL timeout_wait_cnt: got %0d expected %0d", mem_wait_cnt, cexp(16));
        end
        // Reset cycle still shows ERROR; RUN appears after the edge.
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_ERROR || mem_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rst_cycle: ctl=%b err=%b expected ctl=%b err=1", ctl, mem_error, C_ERROR);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE || mem_error !== 1'b0 || mem_wait_cnt !== 16'd0) begin
            errors++;
            $display("FAIL timeout_after_rst: ctl=%b err=%b wait=%0d expected ctl=%b err=0 wait=0",
                     ctl, mem_error, mem_wait_cnt, C_IDLE);
        end
    endtask

    task automatic test_ready_at_timeout();
        do_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < MEM_TIMEOUT; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Last allowed wait cycle: completion beats timeout.
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (ctl !== C_ACCESS) begin
            errors++;
            $display("FAIL ready_at_timeout: ctl=%b expected %b", ctl, C_ACCESS);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_IDLE || mem_error !== 1'b0 || mem_wait_cnt !== cexp(15)) begin
            errors++;
            $display("FAIL ready_at_timeout_run: ctl=%b err=%b wait=%0d expected ctl=%b err=0 wait=%0d",
                     ctl, mem_error, mem_wait_cnt, C_IDLE, cexp(15));
        end
    endtask

    task automatic test_rst_mem_wait();
        do_reset();
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL rst_in_wait_cycle: ctl=%b expected %b", ctl, C_STALL);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE || stall_cnt !== 16'd0 || mem_wait_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_in_wait_after: ctl=%b cnt=%0d/%0d/%0d expected ctl=%b cnt=0/0/0",
                     ctl, stall_cnt, mem_wait_cnt, flush_cnt, C_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (ctl !== C_ACCESS) begin
            errors++;
            $display("FAIL b2b_load: ctl=%b expected %b", ctl, C_ACCESS);
        end
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checks++;
        if (ctl !== C_ACC_HZ) begin
            errors++;
            $display("FAIL b2b_store_hazard: ctl=%b expected %b", ctl, C_ACC_HZ);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_IDLE || mem_wait_cnt !== cexp(0) || stall_cnt !== cexp(1)) begin
            errors++;
            $display("FAIL b2b_end: ctl=%b wait=%0d stall=%0d expected ctl=%b wait=%0d stall=%0d",
                     ctl, mem_wait_cnt, stall_cnt, C_IDLE, cexp(0), cexp(1));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65535) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== cexp(65535)) begin
            errors++;
            $display("FAIL sat_reach: got %0d expected %0d", stall_cnt, cexp(65535));
        end
        repeat (70000 - 65535) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== cexp(65535) || ctl !== C_HAZARD) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d ctl=%b expected cnt=%0d ctl=%b", stall_cnt, ctl, cexp(65535), C_HAZARD);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_hazard();
        test_branch_hazard();
        test_mem_read();
        test_timeout();
        test_ready_at_timeout();
        test_rst_mem_wait();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for one memory access before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hazard_detected  input  1  data hazard from the hazard detection unit (ID stage).
REQ-006 SHALL have port branch_taken  input  1  taken branch or jump resolved in EXE.
REQ-007 SHALL have port mem_r_en  input  1  MEM-stage load.
REQ-008 SHALL have port mem_w_en  input  1  MEM-stage store.
REQ-009 SHALL have port sram_ready  input  1  external memory completes the pending access this cycle.
REQ-010 SHALL have port sram_req  output  1  memory access request.
REQ-011 SHALL have port freeze_pc  output  1  hold PC.
REQ-012 SHALL have port freeze_if_id  output  1  hold IF/ID register.
REQ-013 SHALL have port flush_if_id  output  1  clear IF/ID register to NOP.
REQ-014 SHALL have port bubble_id_exe  output  1  load NOP into ID/EXE register.
REQ-015 SHALL have port freeze_back  output  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
REQ-016 SHALL have port mem_error  output  1  sticky timeout flag.
REQ-017 SHALL have ports stall_cnt, mem_wait_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-018 SHALL implement a state machine with states RUN, MEM_WAIT and ERROR.
REQ-019 SHALL define mem_access = mem_r_en | mem_w_en.
REQ-020 SHALL drive sram_req = 1 in RUN when mem_access = 1, and in MEM_WAIT; sram_req SHALL be 0 otherwise.
REQ-021 SHALL define mem_stall = sram_req & ~sram_ready; all outputs in REQ-021 to REQ-026 SHALL be combinational from state and inputs.
REQ-022 SHALL transition RUN->MEM_WAIT on mem_stall, MEM_WAIT->RUN on sram_ready, and MEM_WAIT->ERROR when the wait counter equals MEM_TIMEOUT with sram_ready = 0.
REQ-023 SHALL hold an internal wait counter: cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle; sram_ready on the same cycle as timeout wins (return to RUN).
REQ-024 SHALL apply output priority ERROR > mem_stall > branch_taken > hazard_detected.
REQ-025 SHALL assert all of freeze_pc, freeze_if_id and freeze_back in ERROR or on mem_stall, with flush_if_id = bubble_id_exe = 0; branch and hazard are ignored in that cycle and re-evaluated after.
REQ-026 SHALL, on branch_taken without higher priority, assert flush_if_id = 1 and bubble_id_exe = 1 with freeze_pc = 0, so that the target loads.
REQ-027 SHALL, on hazard_detected alone, assert freeze_pc = 1, freeze_if_id = 1 and bubble_id_exe = 1, with freeze_back = 0.
REQ-028 SHALL drive all of these outputs to 0 when none of the conditions apply.
REQ-029 SHALL make ERROR absorbing until rst; mem_error = 1 exactly while in ERROR.

Reset
REQ-030 SHALL, when rst = 1 at a clock edge, enter RUN and clear the wait counter, mem_error and all counters, regardless of the current state.
REQ-031 SHALL, in the cycle rst is asserted, drive combinational outputs from the post-reset state (RUN) only after the edge; an in-flight MEM_WAIT access SHALL be abandoned.

Configuration
REQ-032 SHALL, with macro STALL_COUNTER_EN defined, compile in the counters as follows, each saturating at 2^CNT_W-1:
- stall_cnt +1 per hazard-bubble cycle (REQ-027);
- mem_wait_cnt +1 per mem_stall cycle;
- flush_cnt +1 per branch flush (REQ-026).
REQ-033 SHALL, without STALL_COUNTER_EN, keep the counter ports present but tie them to constant 0, with no counter flops.

Verification
REQ-034 SHALL cover: hazard_detected = 1 for 2 cycles with no memory access -> freeze_pc = freeze_if_id = bubble_id_exe = 1 for exactly 2 cycles, freeze_back = 0, stall_cnt = 2.
REQ-035 SHALL cover: branch_taken = 1 and hazard_detected = 1 in the same cycle -> flush_if_id = 1, bubble_id_exe = 1, freeze_pc = 0, flush_cnt = 1.
REQ-036 SHALL cover: mem_r_en = 1 with sram_ready after 3 cycles -> sram_req = 1 for 4 cycles, freeze_back = 1 for 3 cycles, RUN on the 4th edge, mem_wait_cnt = 3.
REQ-037 SHALL cover: mem_w_en = 1 with sram_ready never, MEM_TIMEOUT = 15 -> ERROR after the 15th wait cycle, mem_error = 1 held, and all freezes = 1 until rst.
REQ-038 SHALL cover: rst = 1 during MEM_WAIT -> next cycle in RUN, sram_req = 0 (with mem_access = 0), and counters = 0.
REQ-039 SHALL cover: 70000 hazard cycles with CNT_W = 16 -> stall_cnt = 65535 (saturated); without the macro -> stall_cnt = 0 throughout.
